// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
//   tx_state_t : serializer FSM states (idle, start bit, data bits, stop bit)
//   DATA_BITS  : payload bits per frame
//   FRAME_BITS : total bits per frame (start + data + stop)
//   LINE_IDLE  : serial line level when idle and during the stop bit
//   START_LVL  : serial line level during the start bit
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } tx_state_t;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned FRAME_BITS = 10;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through output.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, flushes all entries
//   push  : write din (ignored when full)
//   pop   : drop the head entry (ignored when empty)
//   din   : byte to write
//   dout  : current head entry, valid whenever empty is low
//   level : number of queued entries, 0..FIFO_DEPTH
//   full  : level == FIFO_DEPTH
//   empty : level == 0
module uart_byte_fifo #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [7:0]         din,
   output logic [7:0]         dout,
   output logic [LEVEL_W-1:0] level,
   output logic               full,
   output logic               empty
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [LEVEL_W-1:0] level_q;
   logic               do_push;
   logic               do_pop;

   assign full    = (level_q == LEVEL_W'(FIFO_DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];
   assign level   = level_q;

   // Storage carries no reset; only the pointers and level define contents.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            level_q <= level_q + LEVEL_W'(1);
         end else if (do_pop && !do_push) begin
            level_q <= level_q - LEVEL_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo_serializer.sv
// 8N1 UART transmitter fed by a byte FIFO; bytes go out LSB-first, back-to-back.
//   wb_clk_i   : clock, rising edge
//   wb_rst_i   : synchronous active-high reset; flushes FIFO and aborts any frame
//   tx_data    : byte to queue
//   tx_valid   : tx_data valid; accepted when tx_ready is high
//   tx_ready   : FIFO not full
//   ser_tx     : registered serial line, idles high
//   busy       : frame in progress or bytes still queued
//   fifo_level : bytes currently queued
module uart_tx_fifo_serializer #(
   parameter int unsigned CLKS_PER_BIT = 625,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned LEVEL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic [7:0]         tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               ser_tx,
   output logic               busy,
   output logic [LEVEL_W-1:0] fifo_level
);

   import uart_pkg::*;

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] BaudLast = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BitLast  = BIT_W'(DATA_BITS - 1);

   tx_state_t         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              ser_tx_q, ser_tx_d;

   logic       fifo_push;
   logic       fifo_pop;
   logic [7:0] fifo_dout;
   logic       fifo_full;
   logic       fifo_empty;
   logic       bit_end;

   assign tx_ready  = ~fifo_full;
   assign fifo_push = tx_valid & tx_ready;
   assign ser_tx    = ser_tx_q;
   assign busy      = (state_q != StIdle) | ~fifo_empty;
   assign bit_end   = (baud_q == BaudLast);

   uart_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LEVEL_W    (LEVEL_W)
   ) u_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (tx_data),
      .dout  (fifo_dout),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               baud_d   = '0;
               bit_d    = '0;
               state_d  = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         StData: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == BitLast) begin
                  bit_d   = '0;
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         StStop: begin
            if (bit_end) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  state_d  = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Line level follows the next state so ser_tx can be a plain register.
      unique case (state_d)
         StStart: ser_tx_d = START_LVL;
         StData:  ser_tx_d = shift_d[bit_d];
         default: ser_tx_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         ser_tx_q <= LINE_IDLE;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         ser_tx_q <= ser_tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// Scoreboard bench for uart_tx_fifo_serializer (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_tx_fifo_serializer;

   import uart_pkg::*;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;
   localparam int unsigned FRAME = FRAME_BITS * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    tx_data = 8'h00;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic          ser_tx;
   logic          busy;
   logic [LW-1:0] fifo_level;

   uart_tx_fifo_serializer #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .LEVEL_W      (LW)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ser_tx     (ser_tx),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   bit         mon_en     = 1'b1;
   int         n_frames   = 0;
   int         prev_start = 0;
   int         last_start = 0;
   string      rx_str     = "";

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Serial monitor: samples each bit mid-period and pops the scoreboard per frame.
   initial begin : monitor
      logic [9:0] fr;
      bit         ok;
      forever begin
         @(negedge clk);
         if (mon_en && ser_tx === 1'b0) begin
            prev_start = last_start;
            last_start = cyc;
            ok = 1'b1;
            for (int i = 0; i < 10; i++) begin
               repeat ((i == 0) ? CPB / 2 : CPB) @(negedge clk);
               if (!mon_en) begin
                  ok = 1'b0;
                  break;
               end
               fr[i] = ser_tx;
            end
            if (ok) begin
               n_frames++;
               check("start_bit", 32'(fr[0]), 32'd0);
               check("stop_bit", 32'(fr[9]), 32'd1);
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_frame: got %02h, required no frame", fr[8:1]);
               end else begin
                  check("frame_byte", 32'(fr[8:1]), 32'(exp_q.pop_front()));
               end
               rx_str = $sformatf("%s%c", rx_str, fr[8:1]);
            end
         end
      end
   end

   // Drive n bytes on consecutive cycles; each must be accepted immediately.
   task automatic push_burst(input int n, input logic [7:0] b0, b1, b2);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tx_data  = (i == 0) ? b0 : (i == 1) ? b1 : b2;
         tx_valid = 1'b1;
         check("tx_ready_at_push", 32'(tx_ready), 32'd1);
         exp_q.push_back(tx_data);
      end
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      bit done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check(name, 32'(done), 32'd1);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int lvl;
      int sent;
      int nf;
      int lows;
      bit rdy_e;
      bit do_push;
      bit do_pop;

      // Reset values
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ser_tx", 32'(ser_tx), 32'd1);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single 0x55 frame: exact line waveform and busy duration
      push_burst(1, 8'h55, 8'h00, 8'h00);
      check("t1_line_before_pop", 32'(ser_tx), 32'd1);
      check("t1_level_1", 32'(fifo_level), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         check($sformatf("t1_line_cycle%0d", i), 32'(ser_tx), 32'((i / 4) & 1));
         @(negedge clk);
      end
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_line_idle", 32'(ser_tx), 32'd1);
      wait_idle(20, "t1_idle");

      // "Hi" back-to-back
      rx_str = "";
      push_burst(2, 8'h48, 8'h69, 8'h00);
      wait_idle(200, "t2_idle");
      check("t2_frame_spacing", 32'(last_start - prev_start), 32'(FRAME));
      check("t2_text_hi", 32'(rx_str == "Hi"), 32'd1);
      $display("[TB] uart rx text: %s", rx_str);

      // Flow control with FIFO full; junk data offered while not ready
      lvl  = 0;
      sent = 0;
      for (int j = 0; j <= 130; j++) begin
         @(negedge clk);
         rdy_e = (lvl != DEPTH);
         check("t3_tx_ready", 32'(tx_ready), 32'(rdy_e));
         check("t3_level", 32'(fifo_level), 32'(lvl));
         do_push = (sent < 8) && rdy_e;
         do_pop  = (j >= 1) && (((j - 1) % FRAME) == 0) && (lvl > 0);
         if (sent < 8) begin
            tx_valid = 1'b1;
            tx_data  = rdy_e ? 8'(8'h10 + sent) : 8'(8'hC0 | (j & 15));
         end else begin
            tx_valid = 1'b0;
         end
         if (do_push) begin
            exp_q.push_back(8'(8'h10 + sent));
            sent++;
         end
         lvl = lvl + int'(do_push) - int'(do_pop);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      wait_idle(400, "t3_drain");

      // Reset during DATA bit 3 of 0x00 with two bytes queued
      push_burst(3, 8'h00, 8'h01, 8'h02);
      repeat (16) @(negedge clk);
      check("t5_mid_frame_low", 32'(ser_tx), 32'd0);
      check("t5_level_2", 32'(fifo_level), 32'd2);
      mon_en = 1'b0;
      exp_q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_ser_tx", 32'(ser_tx), 32'd1);
      check("t5_level", 32'(fifo_level), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_tx_ready", 32'(tx_ready), 32'd1);
      @(negedge clk);
      mon_en = 1'b1;
      nf   = n_frames;
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (ser_tx !== 1'b1) lows++;
      end
      check("t5_line_quiet", 32'(lows), 32'd0);
      check("t5_no_frames", 32'(n_frames - nf), 32'd0);

      // Push on the STOP-end edge of a frame with an empty FIFO
      push_burst(1, 8'hA5, 8'h00, 8'h00);
      repeat (39) @(negedge clk);
      push_burst(1, 8'h3C, 8'h00, 8'h00);
      check("t6_idle_cycle_line", 32'(ser_tx), 32'd1);
      check("t6_level_1", 32'(fifo_level), 32'd1);
      check("t6_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("t6_start_low", 32'(ser_tx), 32'd0);
      wait_idle(200, "t6_idle");
      check("t6_frame_spacing", 32'(last_start - prev_start), 32'(FRAME + 1));

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
